// File: rtl/hazard_scoreboard_pkg.sv
// Shared decoder defines plus scoreboard types used by the hazard scoreboard and its FIFO.
`ifndef HAZARD_DEFINES_SVH
`define HAZARD_DEFINES_SVH
`define ARCH_REG_INDEX_SIZE 5
`define OPCODE_ALU 7'b0110011
`define OPCODE_ALUI 7'b0010011
`define OPCODE_LOAD 7'b0000011
`define OPCODE_STORE 7'b0100011
`define OPCODE_BRANCH 7'b1100011
`define OPCODE_JAL 7'b1101111
`define FUNCT7_MUL 7'b0000001
`define SB_DEPTH_DEFAULT 8
`define MUL_LATENCY_DEFAULT 4
`endif

package hazard_scoreboard_pkg;

    localparam int REG_W           = `ARCH_REG_INDEX_SIZE;
    localparam int SB_DEPTH_DEF    = `SB_DEPTH_DEFAULT;
    localparam int MUL_LATENCY_DEF = `MUL_LATENCY_DEFAULT;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic raw1;
        logic raw2;
        logic waw;
        logic full;
        logic mul;
    } hazard_t;

    function automatic logic any_hazard(input hazard_t h);
        return |h;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fifo.sv
// In-order FIFO of pending destination registers with per-slot match vectors for three lookups.
module sb_fifo
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  reg_idx_t         push_rd,
    input  logic             pop,
    input  logic             flush,
    input  logic [CNT_W-1:0] flush_keep,
    input  reg_idx_t         q1_rd,
    input  reg_idx_t         q2_rd,
    input  reg_idx_t         q3_rd,
    output reg_idx_t         head_rd,
    output logic [DEPTH-1:0] head_oh,
    output logic [DEPTH-1:0] q1_match,
    output logic [DEPTH-1:0] q2_match,
    output logic [DEPTH-1:0] q3_match,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    reg_idx_t         mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] kept;
    logic [DEPTH-1:0] valid_vec;
    logic             do_pop, do_push;
    int               tail_sum;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign head_rd = mem_q[head_q];

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        valid_vec = '0;
        head_oh   = '0;
        q1_match  = '0;
        q2_match  = '0;
        q3_match  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            int off;
            off = i - int'(head_q);
            if (off < 0) off = off + DEPTH;
            valid_vec[i] = (off < int'(count_q));
            head_oh[i]   = (int'(head_q) == i);
            q1_match[i]  = valid_vec[i] && (mem_q[i] == q1_rd);
            q2_match[i]  = valid_vec[i] && (mem_q[i] == q2_rd);
            q3_match[i]  = valid_vec[i] && (mem_q[i] == q3_rd);
        end
    end

    always_comb begin
        kept     = count_q;
        if (flush && (flush_keep < count_q)) kept = flush_keep;
        do_pop   = pop && (kept != '0);
        do_push  = push && !flush && (!full || do_pop);
        count_d  = kept - CNT_W'(do_pop) + CNT_W'(do_push);
        head_d   = do_pop ? ptr_inc(head_q) : head_q;
        tail_sum = int'(head_q) + int'(kept);
        if (tail_sum >= DEPTH) tail_sum = tail_sum - DEPTH;
        tail_d   = tail_q;
        if (flush) begin
            tail_d = PTR_W'(tail_sum);
        end else if (do_push) begin
            tail_d = ptr_inc(tail_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_rd;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: RAW/WAW/capacity/multiplier stalls against in-flight writers.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int SB_DEPTH    = SB_DEPTH_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 dec_valid,
    input  logic [`ARCH_REG_INDEX_SIZE-1:0]      rs1,
    input  logic [`ARCH_REG_INDEX_SIZE-1:0]      rs2,
    input  logic                                 uses_rs1,
    input  logic                                 uses_rs2,
    input  logic [`ARCH_REG_INDEX_SIZE-1:0]      rd,
    input  logic                                 writes_rd,
    input  logic                                 is_mul,
    input  logic                                 wb_valid,
    input  logic [`ARCH_REG_INDEX_SIZE-1:0]      wb_rd,
    input  logic                                 flush,
    input  logic [$clog2(SB_DEPTH+1)-1:0]        flush_keep,
    output logic                                 stall,
    output logic                                 issue,
    output logic [$clog2(SB_DEPTH+1)-1:0]        count,
    output logic                                 full,
    output logic                                 order_err
);

    localparam int CNT_W = $clog2(SB_DEPTH + 1);
    localparam int MUL_W = $clog2(MUL_LATENCY + 1);

    logic [MUL_W-1:0]    mul_cnt_q, mul_cnt_d;
    logic                order_err_q, order_err_d;
    reg_idx_t            head_rd;
    logic [SB_DEPTH-1:0] head_oh, m1, m2, m3, bypass_mask;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                wb_hit, head_ok, pop, push;
    logic                rs1_busy, rs2_busy, rd_busy;
    hazard_t             haz;

    sb_fifo #(
        .DEPTH (SB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_rd    (rd),
        .pop        (pop),
        .flush      (flush),
        .flush_keep (flush_keep),
        .q1_rd      (rs1),
        .q2_rd      (rs2),
        .q3_rd      (rd),
        .head_rd    (head_rd),
        .head_oh    (head_oh),
        .q1_match   (m1),
        .q2_match   (m2),
        .q3_match   (m3),
        .count      (fifo_count),
        .full       (fifo_full)
    );

    assign count     = fifo_count;
    assign full      = fifo_full;
    assign order_err = order_err_q;

    // A writeback to x0 is ignored; any other writeback must match the oldest writer.
    assign wb_hit = wb_valid && (wb_rd != '0);
    assign head_ok = (fifo_count != '0) && (wb_rd == head_rd);
    assign pop = wb_hit && head_ok;

    // The head being retired this cycle no longer blocks its readers.
    assign bypass_mask = pop ? ~head_oh : '1;
    assign rs1_busy = (rs1 != '0) && |(m1 & bypass_mask);
    assign rs2_busy = (rs2 != '0) && |(m2 & bypass_mask);
    assign rd_busy  = (rd  != '0) && |(m3 & bypass_mask);

    always_comb begin
        haz.raw1 = uses_rs1 && rs1_busy;
        haz.raw2 = uses_rs2 && rs2_busy;
        haz.waw  = writes_rd && rd_busy;
        haz.full = fifo_full && writes_rd && (rd != '0) && !pop;
        haz.mul  = is_mul && (mul_cnt_q != '0);
    end

    assign stall = dec_valid && !reset && any_hazard(haz);
    assign issue = dec_valid && !stall && !flush;
    assign push  = issue && writes_rd && (rd != '0);

    always_comb begin
        mul_cnt_d   = mul_cnt_q;
        if (issue && is_mul) begin
            mul_cnt_d = MUL_W'(MUL_LATENCY);
        end else if (mul_cnt_q != '0) begin
            mul_cnt_d = mul_cnt_q - 1'b1;
        end
        order_err_d = order_err_q || (wb_hit && !head_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt_q   <= '0;
            order_err_q <= 1'b0;
        end else begin
            mul_cnt_q   <= mul_cnt_d;
            order_err_q <= order_err_d;
        end
    end

endmodule
